mem_arb_rr: RTL and testbench
=============================

MEM_ARB_RR -- requirements
Module: mem_arb_rr

Interface
REQ-001 Parameter NPORTS, default 2: number of cache requesters; legal range 2..8.
REQ-002 Parameter ADDR_W, default 64: byte address width.
REQ-003 Parameter BLOCK_W, default 512: cache block width in bits.
REQ-004 Parameter FIXED_PRIO, default 0: 0 selects round-robin; 1 selects fixed priority with port 0 highest.
REQ-005 One clock; reset is asynchronous and active-high; the ports are named clk and reset.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port reset, input, 1: asynchronous active-high reset.
REQ-008 Port req, input, NPORTS: per-port request level.
REQ-009 Port wr_en, input, NPORTS: per-port write (1) or read (0).
REQ-010 Port addr, input, NPORTS*ADDR_W: packed per-port address; port i occupies slice i.
REQ-011 Port wdata, input, NPORTS*BLOCK_W: packed per-port write block.
REQ-012 Port rdata, output, BLOCK_W: shared read-return block.
REQ-013 Port done, output, NPORTS: one-hot completion pulse.
REQ-014 Port grant_id, output, $clog2(NPORTS): index of the port currently owning the bus.
REQ-015 Port busy, output, 1: high when the state is not IDLE.
REQ-016 Port mem_req, output, 1: request level to the memory controller.
REQ-017 Port mem_wr_en, output, 1: write qualifier to the memory controller.
REQ-018 Port mem_address, output, ADDR_W: latched address.
REQ-019 Port mem_data_out, output, BLOCK_W: latched write block.
REQ-020 Port mem_data_in, input, BLOCK_W: block returned by memory.
REQ-021 Port mem_data_valid, input, 1: single-cycle completion strobe from memory.

Function
REQ-022 The FSM shall have exactly three states: IDLE, BUSY and RESP.
REQ-023 In IDLE with any req bit high, the block shall pick a winner at the clock edge, latch that port's addr, wdata and wr_en plus the winner index, and enter BUSY.
REQ-024 In round-robin mode the winner shall be the first requesting port at or after rr_ptr, searching upward modulo NPORTS.
REQ-025 In fixed-priority mode the winner shall be the lowest-index requesting port.
REQ-026 While in BUSY, mem_req shall be held high and mem_address, mem_wr_en and mem_data_out shall be held stable from the latched values.
REQ-027 When mem_data_valid is sampled high in BUSY, the block shall register mem_data_in into rdata and enter RESP.
REQ-028 In RESP, done[grant_id] shall be high for exactly one cycle and mem_req shall be low; the next state is IDLE.
REQ-029 On leaving RESP, rr_ptr shall become (grant_id+1) mod NPORTS; it shall wrap from NPORTS-1 to 0.
REQ-030 rdata shall hold its value until the next read completes; write completions shall leave rdata unchanged.
REQ-031 Minimum latency: req sampled at edge k, mem_req high in cycle k+1, mem_data_valid at edge m, done high in cycle m+1.
REQ-032 mem_data_valid shall be ignored in IDLE and RESP.
REQ-033 req bits shall be ignored outside IDLE.
REQ-034 A requester dropping req during BUSY shall not abort the transaction; done shall still pulse.
REQ-035 A requester shall deassert req in the cycle it sees done; a req still high in the following IDLE cycle is a new request.
REQ-036 Simultaneous requests from all ports shall each be served exactly once within NPORTS transactions in round-robin mode.

Reset
REQ-037 Reset shall immediately force state=IDLE, rr_ptr=0, grant_id=0, done=0, busy=0, mem_req=0, mem_wr_en=0, mem_address=0, mem_data_out=0 and rdata=0.
REQ-038 Reset asserted during BUSY shall abandon the transaction with no done pulse.

Structure
REQ-039 The state enum (IDLE/BUSY/RESP) shall reside in a shared package, mem_arb_pkg.
REQ-040 The winner selection shall be a combinational sub-module, rr_pick, parametrised by NPORTS and FIXED_PRIO.

Verification
REQ-041 Single read: NPORTS=2, port1 read of addr 0x1000, valid asserted 5 cycles after mem_req with data 0xA5.. -> mem_address=0x1000, mem_wr_en=0, done=2'b10 for 1 cycle, rdata=0xA5...
REQ-042 Contention in round-robin mode: both ports requesting continuously from reset -> grant order 0,1,0,1 with each done one-hot.
REQ-043 Fixed-priority mode: both ports requesting, FIXED_PRIO=1 -> port0 granted on every transaction while it requests; port1 granted only after port0 drops req.
REQ-044 Write: port0 write of 0x2040 with wdata pattern 0xDEADBEEF.. -> mem_wr_en=1 and mem_data_out stable until valid; rdata unchanged.
REQ-045 Reset mid-BUSY: assert reset 2 cycles into BUSY -> mem_req=0 immediately, no done pulse, next transaction granted to port0.
REQ-046 Wrap-around: NPORTS=4, ports 3 and 0 requesting, rr_ptr=3 -> port3 granted, then port0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states and the arbitration search-order helper.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  function automatic int rr_idx(input int ptr, input int i, input int n, input bit fixed);
    return fixed ? i : (ptr + i) % n;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational winner select, round-robin from ptr or fixed priority (port 0 highest).
module rr_pick import mem_arb_pkg::*; #(
  parameter int NPORTS     = 2,
  parameter bit FIXED_PRIO = 0
) (
  input  logic [NPORTS-1:0]         req,
  input  logic [$clog2(NPORTS)-1:0] ptr,
  output logic [$clog2(NPORTS)-1:0] pick
);
  localparam int IW = $clog2(NPORTS);
  // Walk the search order backwards so the earliest requester in that order wins last.
  always_comb begin
    pick = '0;
    for (int i = NPORTS - 1; i >= 0; i--)
      if (req[rr_idx(int'(ptr), i, NPORTS, FIXED_PRIO)]) pick = IW'(rr_idx(int'(ptr), i, NPORTS, FIXED_PRIO));
  end
endmodule

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: arbitrates NPORTS cache requesters onto one memory controller port.
module mem_arb_rr import mem_arb_pkg::*; #(
  parameter int NPORTS     = 2,
  parameter int ADDR_W     = 64,
  parameter int BLOCK_W    = 512,
  parameter bit FIXED_PRIO = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NPORTS-1:0]           req,
  input  logic [NPORTS-1:0]           wr_en,
  input  logic [NPORTS*ADDR_W-1:0]    addr,
  input  logic [NPORTS*BLOCK_W-1:0]   wdata,
  output logic [BLOCK_W-1:0]          rdata,
  output logic [NPORTS-1:0]           done,
  output logic [$clog2(NPORTS)-1:0]   grant_id,
  output logic                        busy,
  output logic                        mem_req,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [BLOCK_W-1:0]          mem_data_out,
  input  logic [BLOCK_W-1:0]          mem_data_in,
  input  logic                        mem_data_valid
);
  localparam int IW = $clog2(NPORTS);
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, pick;
  logic [ADDR_W-1:0] addr_a [NPORTS];
  logic [BLOCK_W-1:0] wdata_a [NPORTS];
  for (genvar p = 0; p < NPORTS; p++) begin : g_unpack
    assign addr_a[p] = addr[p*ADDR_W +: ADDR_W];
    assign wdata_a[p] = wdata[p*BLOCK_W +: BLOCK_W];
  end
  rr_pick #(.NPORTS(NPORTS), .FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick)
  );
  always_comb begin
    state_n = (state == IDLE && |req) ? BUSY :
              (state == BUSY && mem_data_valid) ? RESP :
              (state == RESP) ? IDLE : state;
    busy = state != IDLE;
    mem_req = state == BUSY;
    done = (state == RESP) ? NPORTS'(1) << grant_id : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr_ptr <= '0;
      grant_id <= '0;
      mem_wr_en <= 1'b0;
      mem_address <= '0;
      mem_data_out <= '0;
      rdata <= '0;
    end else begin
      if (state == IDLE && |req) begin
        grant_id <= pick;
        mem_wr_en <= wr_en[pick];
        mem_address <= addr_a[pick];
        mem_data_out <= wdata_a[pick];
      end
      if (state == BUSY && mem_data_valid && !mem_wr_en) rdata <= mem_data_in;
      if (state == RESP) rr_ptr <= (grant_id == IW'(NPORTS - 1)) ? '0 : grant_id + 1'b1;
    end
endmodule

// File: tb/tb_mem_arb_rr.sv
// tb_mem_arb_rr: transaction model for a 2-port round-robin arbiter plus directed runs of fixed-priority and 4-port variants.
module tb_mem_arb_rr;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [1:0] req = '0, wr_en = '0, done;
  logic [127:0] addr = '0;
  logic [1023:0] wdata = '0;
  logic [511:0] rdata, mem_data_out, mem_data_in = '0;
  logic [63:0] mem_address;
  logic grant_id, busy, mem_req, mem_wr_en, mem_data_valid = 0;
  mem_arb_rr dut (
    .clk(clk), .reset(reset), .req(req), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .grant_id(grant_id), .busy(busy), .mem_req(mem_req),
    .mem_wr_en(mem_wr_en), .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid)
  );
  logic [1:0] fp_req = '0, fp_done;
  logic [7:0] fp_rdata, fp_mdo;
  logic [15:0] fp_maddr;
  logic fp_gid, fp_busy, fp_mem_req, fp_mwr, fp_valid = 0;
  mem_arb_rr #(.NPORTS(2), .ADDR_W(16), .BLOCK_W(8), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset), .req(fp_req), .wr_en(2'b00), .addr(32'h0), .wdata(16'h0),
    .rdata(fp_rdata), .done(fp_done), .grant_id(fp_gid), .busy(fp_busy), .mem_req(fp_mem_req),
    .mem_wr_en(fp_mwr), .mem_address(fp_maddr), .mem_data_out(fp_mdo),
    .mem_data_in(8'h5A), .mem_data_valid(fp_valid)
  );
  logic [3:0] w4_req = '0, w4_done;
  logic [7:0] w4_rdata, w4_mdo;
  logic [15:0] w4_maddr;
  logic [1:0] w4_gid;
  logic w4_busy, w4_mem_req, w4_mwr, w4_valid = 0;
  mem_arb_rr #(.NPORTS(4), .ADDR_W(16), .BLOCK_W(8), .FIXED_PRIO(0)) u_w4 (
    .clk(clk), .reset(reset), .req(w4_req), .wr_en(4'b0000), .addr(64'h0), .wdata(32'h0),
    .rdata(w4_rdata), .done(w4_done), .grant_id(w4_gid), .busy(w4_busy), .mem_req(w4_mem_req),
    .mem_wr_en(w4_mwr), .mem_address(w4_maddr), .mem_data_out(w4_mdo),
    .mem_data_in(8'hC3), .mem_data_valid(w4_valid)
  );
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Transaction-level reference: owner < 0 means no transaction in flight.
  int m_owner = -1, m_ptr = 0, m_gid = 0;
  bit m_resp = 0;
  logic m_wr = 0;
  logic [63:0] m_addr = '0;
  logic [511:0] m_wdata = '0, m_rdata = '0;
  always @(posedge clk or posedge reset) begin : mdl
    int w;
    w = -1;
    if (reset) begin
      m_owner <= -1; m_resp <= 0; m_ptr <= 0; m_gid <= 0;
      m_wr <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (m_resp) begin
      m_resp <= 0; m_owner <= -1; m_ptr <= (m_owner + 1) % 2;
    end else if (m_owner >= 0) begin
      if (mem_data_valid) begin
        m_resp <= 1;
        if (!m_wr) m_rdata <= mem_data_in;
      end
    end else begin
      for (int k = 0; k < 2; k++) if (w < 0 && req[(m_ptr + k) % 2]) w = (m_ptr + k) % 2;
      if (w >= 0) begin
        m_owner <= w; m_gid <= w; m_wr <= wr_en[w];
        m_addr <= addr[w*64 +: 64]; m_wdata <= wdata[w*512 +: 512];
      end
    end
  end
  always @(negedge clk) begin
    chk("busy", busy, m_owner >= 0);
    chk("mem_req", mem_req, m_owner >= 0 && !m_resp);
    chk("done", done, m_resp ? (2'b01 << m_owner) : 2'b00);
    chk("grant_id", grant_id, m_gid);
    chk("mem_wr_en", mem_wr_en, m_wr);
    chk("mem_address", mem_address, m_addr);
    chk("mem_data_out", mem_data_out, m_wdata);
    chk("rdata", rdata, m_rdata);
  end
  task automatic serve(input int exp, input logic [7:0] d);
    for (int t = 0; t < 20 && !mem_req; t++) cyc(1);
    chk("serve_mem_req", mem_req, 1'b1);
    mem_data_valid = 1; mem_data_in = {64{d}};
    cyc(1);
    mem_data_valid = 0;
    chk("serve_grant", grant_id, exp);
    chk("serve_done", done, 2'b01 << exp);
  endtask
  task automatic fp_txn(input int exp);
    for (int t = 0; t < 20 && !fp_mem_req; t++) cyc(1);
    chk("fp_mem_req", fp_mem_req, 1'b1);
    chk("fp_grant", fp_gid, exp);
    fp_valid = 1;
    cyc(1);
    fp_valid = 0;
    chk("fp_done", fp_done, 2'b01 << exp);
  endtask
  task automatic w4_txn(input int exp);
    for (int t = 0; t < 20 && !w4_mem_req; t++) cyc(1);
    chk("w4_mem_req", w4_mem_req, 1'b1);
    chk("w4_grant", w4_gid, exp);
    w4_valid = 1;
    cyc(1);
    w4_valid = 0;
    chk("w4_done", w4_done, 4'b0001 << exp);
    chk("w4_rdata", w4_rdata, 8'hC3);
  endtask
  initial begin
    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    cyc(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 512'h0);
    chk("rst_addr", mem_address, 64'h0);
    reset = 0;
    req = 2'b10; addr = {64'h1000, 64'h0};
    cyc(1);
    req = 2'b00;
    chk("rd_addr", mem_address, 64'h1000);
    chk("rd_mem_req", mem_req, 1'b1);
    chk("rd_wr_en", mem_wr_en, 1'b0);
    cyc(4);
    mem_data_valid = 1; mem_data_in = {64{8'hA5}};
    cyc(1);
    mem_data_valid = 0;
    chk("rd_done", done, 2'b10);
    chk("rd_resp_mem_req", mem_req, 1'b0);
    cyc(1);
    chk("rd_done_low", done, 2'b00);
    chk("rd_rdata", rdata, {64{8'hA5}});
    mem_data_valid = 1; mem_data_in = {64{8'hFF}};
    cyc(1);
    mem_data_valid = 0;
    chk("idle_valid_ignored", rdata, {64{8'hA5}});
    reset = 1;
    cyc(1);
    reset = 0; req = 2'b11;
    for (int k = 0; k < 4; k++) serve(k % 2, dat[k]);
    req = 2'b00;
    cyc(1);
    req = 2'b01; wr_en = 2'b01; addr = {64'h0, 64'h2040}; wdata = {512'h0, {16{32'hDEADBEEF}}};
    cyc(1);
    req = 2'b00;
    chk("wr_wr_en", mem_wr_en, 1'b1);
    chk("wr_addr", mem_address, 64'h2040);
    chk("wr_data", mem_data_out, {16{32'hDEADBEEF}});
    cyc(2);
    serve(0, 8'h77);
    cyc(1);
    chk("wr_rdata_kept", rdata, {64{8'h44}});
    wr_en = 2'b00; req = 2'b11;
    cyc(1);
    chk("rst_mid_grant", grant_id, 1'b1);
    cyc(2);
    reset = 1;
    #1;
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_done", done, 2'b00);
    cyc(1);
    reset = 0;
    serve(0, 8'h99);
    req = 2'b00;
    cyc(2);
    fp_req = 2'b11;
    for (int k = 0; k < 3; k++) fp_txn(0);
    fp_req = 2'b10;
    fp_txn(1);
    fp_req = 2'b00;
    cyc(2);
    w4_req = 4'b0100;
    w4_txn(2);
    w4_req = 4'b1001;
    w4_txn(3);
    w4_txn(0);
    w4_req = 4'b0000;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
